serial2b_to_parallel: RTL and testbench
=======================================

Name: serial2b_to_parallel

Overview:
- Receive end of the 2-bit serial link: converts a 2-bit-per-cycle serial stream back into 8-bit parallel words.
- Runs on the 4f clock from the clock generator. The transmitter sends one byte as four 2-bit pairs per f period, MSB pair first.
- Aligns to the byte boundary by hunting for the comma/idle symbol 0xBC. Declares lock after a run of aligned commas. Once locked, delivers one byte per four cycles with a valid strobe; idle commas are suppressed.

Parameters:
- COMMA, 8'hBC, idle/alignment symbol.
- BC_LOCK, 4, number of consecutive aligned commas required to enter LOCKED (1..15).

Ports:
- clk4f  input  1  sole clock; all logic on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  2  serial pair; bit[1] is the more significant bit of the pair.
- data_out  output  8  recovered byte, registered.
- valid_out  output  1  one-cycle strobe: data_out holds a new non-comma byte.
- active  output  1  high while the receiver is in LOCKED.

Behaviour:
- Reset (reset_L=0, asynchronous) forces the following, held while reset is low:
  - state=SEARCH, phase=0, shift=0, bc_cnt=0
  - data_out=8'h00, valid_out=0, active=0
- Every posedge: shift[5:0] <= {shift[3:0], data_in}.
- Candidate word w = {shift[5:0], data_in} (combinational): the byte whose last pair arrives this edge.
- phase is a 2-bit byte-position counter that wraps 3->0. It is re-zeroed on alignment.
- A boundary edge is an edge where phase==3.
- SEARCH (checks every edge, ignores phase):
  - If w==COMMA: phase<=0, bc_cnt<=1, then go to ALIGN, or directly to LOCKED if BC_LOCK==1.
  - Otherwise: phase increments and the state is held.
- ALIGN (checks boundary edges only):
  - w==COMMA: bc_cnt<=bc_cnt+1. When bc_cnt+1==BC_LOCK, go to LOCKED.
  - w!=COMMA: go to SEARCH, bc_cnt<=0.
  - Non-boundary edges: no state change.
- LOCKED (checks boundary edges only):
  - Every boundary edge: data_out<=w; valid_out<=(w!=COMMA).
  - All other edges: valid_out<=0 and data_out holds its value.
  - LOCKED is left only by reset. There is no loss-of-lock detection in this block.
- active <= (next state == LOCKED), so active rises on the same edge that enters LOCKED.
- Latency: data_out and valid_out update on the same edge that samples the 4th pair, so the outputs are visible in the cycle after the last pair is on data_in.
- The byte at the edge that enters LOCKED is a comma and is not emitted.
- Commas in the data stream after lock are dropped: valid_out stays 0 and data_out is updated to COMMA.
- In SEARCH, a false COMMA match straddling byte boundaries is accepted. Such a misalignment is rejected in ALIGN by the next boundary check.
- If reset is asserted mid-byte, the partial byte is discarded and the hunt restarts from SEARCH.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset_L=0 for 3 cycles, release, drive 0xBC continuously (pairs 2,3,3,0).
  - Expect: active=1 after 4 commas, on the 16th pair edge. valid_out never asserts. data_out=8'hBC once locked.
- Data after lock:
  - Stimulus: after lock, send 0x5A, 0xFF, 0x00.
  - Expect: valid_out pulses exactly one cycle per byte, every 4 cycles, with data_out=5A, FF, 00 respectively.
- Misaligned start:
  - Stimulus: prepend a single pair 2'b01, then a comma stream.
  - Expect: SEARCH finds the comma at the shifted phase; lock after 4 commas; subsequent bytes are correctly framed.
- Broken alignment:
  - Stimulus: send 2 commas, then 0x12, then 4 commas.
  - Expect: return to SEARCH at the 0x12 boundary with active=0; lock achieved only after the following 4 commas.
- Mid-operation reset:
  - Stimulus: assert reset_L=0 asynchronously between edges during byte 0x5A.
  - Expect: all outputs go to 0 immediately; re-lock requires 4 new commas.
- BC_LOCK=1 variant:
  - Stimulus: single comma, then 0xA5.
  - Expect: active rises on the comma's edge; valid_out strobes with data_out=A5.

Source files
------------

// File: rtl/serial2b_to_parallel.sv
// Receive side of the 2-bit serial link: rebuilds 8-bit words from MSB-first pairs on the 4f clock.
// Hunts for the comma symbol, locks after BC_LOCK aligned commas, then frames one byte every four edges.
module serial2b_to_parallel #(
   parameter logic [7:0]  COMMA   = 8'hBC,
   parameter int unsigned BC_LOCK = 4
) (
   input  logic       clk4f,
   input  logic       reset_L,
   input  logic [1:0] data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] BC_LOCK_C = 4'(BC_LOCK);

   state_t     state_q,  state_d;
   logic [1:0] phase_q,  phase_d;
   logic [5:0] shift_q,  shift_d;
   logic [3:0] bc_cnt_q, bc_cnt_d;
   logic [7:0] data_q,   data_d;
   logic       valid_q,  valid_d;
   logic       active_q, active_d;

   logic [7:0] word;
   logic       is_comma;
   logic       boundary;

   // The candidate byte includes the pair being sampled on this edge.
   assign word     = {shift_q, data_in};
   assign is_comma = (word == COMMA);
   assign boundary = (phase_q == 2'd3);
   assign shift_d  = {shift_q[3:0], data_in};

   // State register
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values;
   //       blocking (=) here would create order-dependent races between the registers.
   always_ff @(posedge clk4f or negedge reset_L) begin
      if (!reset_L) begin
         state_q  <= SEARCH;
         phase_q  <= 2'd0;
         shift_q  <= 6'd0;
         bc_cnt_q <= 4'd0;
         data_q   <= 8'h00;
         valid_q  <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         shift_q  <= shift_d;
         bc_cnt_q <= bc_cnt_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         active_q <= active_d;
      end
   end

   // Next-state logic
   // NOTE: every signal driven here gets a default first; a path that skips an assignment
   //       would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q + 2'd1;
      bc_cnt_d = bc_cnt_q;

      unique case (state_q)
         SEARCH: begin
            if (is_comma) begin
               phase_d  = 2'd0;
               bc_cnt_d = 4'd1;
               state_d  = (BC_LOCK_C == 4'd1) ? LOCKED : ALIGN;
            end
         end
         ALIGN: begin
            if (boundary) begin
               if (is_comma) begin
                  bc_cnt_d = bc_cnt_q + 4'd1;
                  if (bc_cnt_q + 4'd1 == BC_LOCK_C) begin
                     state_d = LOCKED;
                  end
               end else begin
                  bc_cnt_d = 4'd0;
                  state_d  = SEARCH;
               end
            end
         end
         LOCKED: begin
            // Held until reset; there is no loss-of-lock path.
            state_d = LOCKED;
         end
         default: begin
            state_d  = SEARCH;
            bc_cnt_d = 4'd0;
         end
      endcase
   end

   // Output logic: frame on boundary edges once locked, dropping idle commas.
   always_comb begin
      data_d   = data_q;
      valid_d  = 1'b0;
      active_d = (state_d == LOCKED);

      if (state_q == LOCKED && boundary) begin
         data_d  = word;
         valid_d = !is_comma;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign active    = active_q;

endmodule

// File: tb/tb_serial2b_to_parallel.sv
// Self-checking bench for serial2b_to_parallel: BC_LOCK=4 instance for the main scenarios,
// BC_LOCK=1 instance for the single-comma lock case.
module tb_serial2b_to_parallel;

   localparam logic [7:0] COMMA = 8'hBC;

   typedef struct {
      logic [7:0] byte_v;
      logic       exp_valid;
   } vec_t;

   logic       clk4f = 1'b0;
   logic       reset_L;
   logic [1:0] data_in, data_in1;
   logic [7:0] data_out, data_out1;
   logic       valid_out, valid_out1, active, active1;

   always #5 clk4f = ~clk4f;

   serial2b_to_parallel #(.COMMA(8'hBC), .BC_LOCK(4)) dut (
      .clk4f     (clk4f),
      .reset_L   (reset_L),
      .data_in   (data_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .active    (active)
   );

   serial2b_to_parallel #(.COMMA(8'hBC), .BC_LOCK(1)) dut1 (
      .clk4f     (clk4f),
      .reset_L   (reset_L),
      .data_in   (data_in1),
      .data_out  (data_out1),
      .valid_out (valid_out1),
      .active    (active1)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_q1[$];

   logic [7:0] o_data;
   logic       o_valid, o_active;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Drive one pair to the selected DUT, sample #1 after the edge, score any valid strobe.
   task automatic step(input bit sel, input logic [1:0] p);
      logic [7:0] e;
      if (sel) begin data_in1 = p; data_in = 2'b00; end
      else     begin data_in  = p; data_in1 = 2'b00; end
      @(posedge clk4f);
      #1;
      o_data   = sel ? data_out1  : data_out;
      o_valid  = sel ? valid_out1 : valid_out;
      o_active = sel ? active1    : active;
      if (o_valid) begin
         if (sel ? (exp_q1.size() == 0) : (exp_q.size() == 0)) begin
            check("unexpected_valid", {7'd0, o_valid}, 8'h00);
         end else begin
            e = sel ? exp_q1.pop_front() : exp_q.pop_front();
            check("scoreboard_data", o_data, e);
         end
      end
   endtask

   // Four pairs MSB first; checks the strobe timing and the framed byte when locked.
   task automatic send_byte(input bit sel, input logic [7:0] b, input logic exp_valid,
                            input bit locked);
      for (int i = 3; i >= 0; i--) begin
         if (i == 0 && locked && exp_valid) begin
            if (sel) exp_q1.push_back(b);
            else     exp_q.push_back(b);
         end
         step(sel, b[2*i +: 2]);
         if (locked) begin
            if (i != 0) check("valid_mid_byte", {7'd0, o_valid}, 8'h00);
            else begin
               check("valid_at_boundary", {7'd0, o_valid}, {7'd0, exp_valid});
               check("data_at_boundary", o_data, b);
            end
         end
      end
   endtask

   // n commas, checking active after every pair; lock expected after pair lock_at (0 = never).
   task automatic comma_run(input bit sel, input int n, input int lock_at, input string name);
      logic [7:0] c;
      c = COMMA;
      for (int k = 0; k < 4 * n; k++) begin
         step(sel, c[2*(3 - (k % 4)) +: 2]);
         check(name, {7'd0, o_active}, {7'd0, (lock_at != 0 && k + 1 >= lock_at)});
      end
   endtask

   task automatic do_reset();
      reset_L  = 1'b0;
      data_in  = 2'b00;
      data_in1 = 2'b00;
      repeat (3) @(posedge clk4f);
      #1;
      check("rst_data_out", data_out, 8'h00);
      check("rst_valid",    {7'd0, valid_out}, 8'h00);
      check("rst_active",   {7'd0, active}, 8'h00);
      check("rst_active1",  {7'd0, active1}, 8'h00);
      reset_L = 1'b1;
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'h5A, 1'b1};
      vecs[1] = '{8'hFF, 1'b1};
      vecs[2] = '{8'h00, 1'b1};
      vecs[3] = '{8'hBC, 1'b0};
      vecs[4] = '{8'hC3, 1'b1};
      vecs[5] = '{8'h3C, 1'b1};

      // Reset, then an idle stream: lock on the 16th pair, commas never strobe.
      do_reset();
      comma_run(1'b0, 4, 16, "lock_active");
      send_byte(1'b0, COMMA, 1'b0, 1'b1);
      check("idle_data_bc", o_data, COMMA);

      // Data after lock, table driven.
      for (int v = 0; v < 6; v++) begin
         send_byte(1'b0, vecs[v].byte_v, vecs[v].exp_valid, 1'b1);
      end

      // Misaligned start: one stray pair shifts the comma by one position.
      do_reset();
      step(1'b0, 2'b01);
      check("misalign_pre", {7'd0, o_active}, 8'h00);
      comma_run(1'b0, 4, 16, "misalign_lock");
      send_byte(1'b0, 8'hA5, 1'b1, 1'b1);
      send_byte(1'b0, 8'h69, 1'b1, 1'b1);

      // Broken alignment: 0x12 after two commas forces a fresh hunt.
      do_reset();
      comma_run(1'b0, 2, 0, "broken_pre");
      send_byte(1'b0, 8'h12, 1'b0, 1'b0);
      check("broken_active", {7'd0, o_active}, 8'h00);
      check("broken_no_data", o_data, 8'h00);
      comma_run(1'b0, 4, 16, "broken_relock");
      send_byte(1'b0, 8'h7E, 1'b1, 1'b1);

      // Asynchronous reset between edges while 0x5A is half received.
      send_byte(1'b0, COMMA, 1'b0, 1'b1);
      check("pre_reset_data", data_out, COMMA);
      step(1'b0, 2'b01);
      step(1'b0, 2'b01);
      #2;
      reset_L = 1'b0;
      #1;
      check("async_rst_data",   data_out, 8'h00);
      check("async_rst_active", {7'd0, active}, 8'h00);
      check("async_rst_valid",  {7'd0, valid_out}, 8'h00);
      @(posedge clk4f);
      #1;
      reset_L = 1'b1;
      comma_run(1'b0, 4, 16, "reset_relock");
      send_byte(1'b0, 8'h5A, 1'b1, 1'b1);

      // BC_LOCK=1: a single comma locks, the next byte is delivered.
      do_reset();
      comma_run(1'b1, 1, 4, "bc1_lock");
      send_byte(1'b1, 8'hA5, 1'b1, 1'b1);
      send_byte(1'b1, COMMA, 1'b0, 1'b1);

      check("scoreboard_drained", 8'(exp_q.size() + exp_q1.size()), 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
